// File: rtl/karatsuba_seq_ctrl.sv
// ---------------------------------------------------------------------------
// karatsuba_seq_ctrl
//
// Sequential N x N -> 2N unsigned multiplier using one Karatsuba step.
// A single (H+1)x(H+1) multiplier is time-shared over three passes:
//   P_LO : z0 = aL * bL
//   P_HI : z2 = aH * bH
//   P_MID: z1 = (aL + aH) * (bL + bH)
//   SUM  : res = (z2 << N) + ((z1 - z2 - z0) << H) + z0
// After the result is registered the block sits in DONE until it is consumed.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer may not withdraw nothing is stored on the input side
// beyond the accept edge; res/out_valid hold steady while out_valid && !out_ready.
//
// Optional feature (macro KARATSUBA_SEQ_ZERO_SKIP_EN): when defined, an
// accepted pair with a zero operand jumps straight from IDLE to DONE with
// res = 0. When undefined, zero operands take the normal full sequence.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair a/b present
//   in_ready   block accepts operands this cycle (IDLE only)
//   a, b       N-bit unsigned operands
//   out_valid  res holds a completed product (DONE)
//   out_ready  consumer takes res this cycle
//   res        registered 2N-bit product
//   busy       high in every state except IDLE
//   state_dbg  current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module karatsuba_seq_ctrl #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] res,
    output logic           busy,
    output logic [2:0]     state_dbg
);

    localparam int H = N / 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        P_LO  = 3'd1,
        P_HI  = 3'd2,
        P_MID = 3'd3,
        SUM   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0]   a_q, b_q;
    logic [N-1:0]   z0_q, z2_q;     // products of two H-bit halves fit in N bits
    logic [N+1:0]   z1_q;           // product of two (H+1)-bit half-sums
    logic [H:0]     sum_a, sum_b;
    logic [H:0]     mul_x, mul_y;
    logic [N+1:0]   mul_p;
    logic           accept;
    logic           zero_op;
    logic [2*N+1:0] z0_w, z1_w, z2_w;

    assign accept = in_valid && (state_q == IDLE);

`ifdef KARATSUBA_SEQ_ZERO_SKIP_EN
    assign zero_op = (a == '0) || (b == '0);
`else
    assign zero_op = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (accept) state_d = zero_op ? DONE : P_LO;
            end
            P_LO:  state_d = P_HI;
            P_HI:  state_d = P_MID;
            P_MID: state_d = SUM;
            SUM:   state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_dbg = state_q;

    // ---------------- shared multiplier ----------------
    // Half-sums are H+1 bits so the carry out of aL + aH is kept.
    assign sum_a = {1'b0, a_q[H-1:0]} + {1'b0, a_q[N-1:H]};
    assign sum_b = {1'b0, b_q[H-1:0]} + {1'b0, b_q[N-1:H]};

    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state_q)
            P_LO: begin
                mul_x = {1'b0, a_q[H-1:0]};
                mul_y = {1'b0, b_q[H-1:0]};
            end
            P_HI: begin
                mul_x = {1'b0, a_q[N-1:H]};
                mul_y = {1'b0, b_q[N-1:H]};
            end
            P_MID: begin
                mul_x = sum_a;
                mul_y = sum_b;
            end
            default: begin
                mul_x = '0;
                mul_y = '0;
            end
        endcase
    end

    assign mul_p = {{(H+1){1'b0}}, mul_x} * {{(H+1){1'b0}}, mul_y};

    // Recombination is done at 2N+2 bits; the true product fits in 2N bits,
    // so dropping the top two bits never loses information.
    assign z0_w = {{(N+2){1'b0}}, z0_q};
    assign z2_w = {{(N+2){1'b0}}, z2_q};
    assign z1_w = {{N{1'b0}}, z1_q};

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            z0_q <= '0;
            z1_q <= '0;
            z2_q <= '0;
            res  <= '0;
        end else begin
            if (accept) begin
                a_q <= a;
                b_q <= b;
                if (zero_op) res <= '0;
            end
            case (state_q)
                P_LO:  z0_q <= mul_p[N-1:0];
                P_HI:  z2_q <= mul_p[N-1:0];
                P_MID: z1_q <= mul_p;
                SUM:   res  <= (2*N)'((z2_w << N) + ((z1_w - z2_w - z0_w) << H) + z0_w);
                default: ;
            endcase
        end
    end

endmodule
